// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package ifetch_pkg;
   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

   typedef enum logic [1:0] {IDLE, RUN, HALT} fetch_state_t;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } fetch_pkt_t;

   function automatic logic is_misaligned(input logic [1:0] low_bits);
      return low_bits != 2'b00;
   endfunction
endpackage

// File: rtl/ifetch_out_if.sv
// Fetch-to-decode valid/ready handshake carrying {instr, pc}.
interface ifetch_out_if;
   import ifetch_pkg::*;

   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_instr;
   logic [XLEN-1:0] out_pc;

   modport master (output out_valid, output out_instr, output out_pc, input out_ready);
   modport slave  (input out_valid, input out_instr, input out_pc, output out_ready);
endinterface

// File: rtl/ifetch_perf_ctr.sv
// Accepted-handshake and stall-cycle counters for the fetch stage; both wrap
// at 2**32 and hold while count_en is low.
module ifetch_perf_ctr (
   input  logic        clk,
   input  logic        reset,
   input  logic        count_en,
   input  logic        fire,
   input  logic        stall,
   output logic [31:0] fetch_cnt,
   output logic [31:0] stall_cnt
);
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_cnt <= '0;
         stall_cnt <= '0;
      end else if (count_en) begin
         if (fire)  fetch_cnt <= fetch_cnt + 32'd1;
         if (stall) stall_cnt <= stall_cnt + 32'd1;
      end
   end
endmodule

// File: rtl/instr_fetch_stage.sv
// PC/fetch stage in front of the instruction ROM. Optional performance
// counters are added when IFETCH_PERF_EN is defined.
//
// state | meaning
// IDLE  | no fetch; waits for fetch_en, redirects still load the PC
// RUN   | fetching one word per cycle into the output slot
// HALT  | misaligned redirect seen; frozen until reset
module instr_fetch_stage
   import ifetch_pkg::*;
#(
   parameter int              ADDR_W    = 12,
   parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
   parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fetch_en,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [XLEN-1:0]   rom_data,
   input  logic              redirect_valid,
   input  logic [XLEN-1:0]   redirect_pc,
   ifetch_out_if.master      out_bus,
   output logic              fetch_err
`ifdef IFETCH_PERF_EN
   ,
   output logic [31:0]       perf_fetch_cnt,
   output logic [31:0]       perf_stall_cnt
`endif
);
   fetch_state_t    state;
   logic [XLEN-1:0] pc;
   logic            valid_q;
   fetch_pkt_t      slot_q;
   logic            slot_free;

   assign rom_addr  = pc[ADDR_W+1:2];
   assign slot_free = ~valid_q | out_bus.out_ready;

   // The slot instruction is masked rather than cleared so a flush never needs a write.
   assign out_bus.out_valid = valid_q;
   assign out_bus.out_instr = valid_q ? slot_q.instr : NOP_INSTR;
   assign out_bus.out_pc    = slot_q.pc;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         pc        <= RESET_PC;
         valid_q   <= 1'b0;
         slot_q    <= '{instr: NOP_INSTR, pc: '0};
         fetch_err <= 1'b0;
      end else begin
         case (state)
            IDLE, RUN: begin
               if (redirect_valid) begin
                  valid_q <= 1'b0;
                  if (is_misaligned(redirect_pc[1:0])) begin
                     fetch_err <= 1'b1;
                     state     <= HALT;
                  end else begin
                     pc <= redirect_pc;
                  end
               end else if (state == IDLE) begin
                  if (fetch_en) state <= RUN;
               end else if (fetch_en && slot_free) begin
                  slot_q  <= '{instr: rom_data, pc: pc};
                  valid_q <= 1'b1;
                  pc      <= pc + 32'd4;
               end else if (!fetch_en && out_bus.out_ready) begin
                  valid_q <= 1'b0;
               end
            end
            HALT:    valid_q <= 1'b0;
            default: state   <= IDLE;
         endcase
      end
   end

`ifdef IFETCH_PERF_EN
   ifetch_perf_ctr u_perf (
      .clk       (clk),
      .reset     (reset),
      .count_en  (state != HALT),
      .fire      (valid_q & out_bus.out_ready),
      .stall     (valid_q & ~out_bus.out_ready),
      .fetch_cnt (perf_fetch_cnt),
      .stall_cnt (perf_stall_cnt)
   );
`endif
endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage with a behavioural ROM; perf counter
// checks compile in when IFETCH_PERF_EN is defined.
module tb_instr_fetch_stage;
   logic        clk = 1'b0;
   logic        reset;
   logic        fetch_en;
   logic [11:0] rom_addr;
   logic [31:0] rom_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        fetch_err;
   logic [31:0] rom [0:4095];
`ifdef IFETCH_PERF_EN
   logic [31:0] perf_fetch_cnt;
   logic [31:0] perf_stall_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   ifetch_out_if bus ();

   instr_fetch_stage dut (
      .clk            (clk),
      .reset          (reset),
      .fetch_en       (fetch_en),
      .rom_addr       (rom_addr),
      .rom_data       (rom_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_bus        (bus),
      .fetch_err      (fetch_err)
`ifdef IFETCH_PERF_EN
      ,
      .perf_fetch_cnt (perf_fetch_cnt),
      .perf_stall_cnt (perf_stall_cnt)
`endif
   );

   always #5 clk = ~clk;
   assign rom_data = rom[rom_addr];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input logic v, input logic [31:0] pc_e,
                            input logic [31:0] instr_e);
      check_val({tag, "_valid"}, {31'd0, bus.out_valid}, {31'd0, v});
      check_val({tag, "_instr"}, bus.out_instr, instr_e);
      if (v) check_val({tag, "_pc"}, bus.out_pc, pc_e);
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) rom[i] = 32'hE000_0000 | i;
      rom[0]       = 32'h1122_3344;
      rom[1]       = 32'hAABB_CCDD;
      rom[2]       = 32'h0011_2233;
      rom[3]       = 32'hAABB_CC21;
      rom[4]       = 32'h1122_7799;
      rom[5]       = 32'h5566_7788;
      rom[12'hFFF] = 32'hFEED_F00D;

      reset = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      bus.out_ready = 1'b1;
      tick(); tick();
      reset = 1'b0;
      check_out("rst", 1'b0, 32'h0, 32'h0000_0013);
      check_val("rst_out_pc", bus.out_pc, 32'h0);
      check_val("rst_err", {31'd0, fetch_err}, 32'd0);
      check_val("rst_addr", {20'd0, rom_addr}, 32'd0);

      // straight-line fetch
      fetch_en = 1'b1;
      tick(); check_out("t1_e1", 1'b0, 32'h0, 32'h0000_0013);
      tick(); check_out("t1_pc0", 1'b1, 32'h0, 32'h1122_3344);
      tick(); check_out("t1_pc4", 1'b1, 32'h4, 32'hAABB_CCDD);

      // backpressure
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_out("t2_hold", 1'b1, 32'h4, 32'hAABB_CCDD);
         check_val("t2_addr", {20'd0, rom_addr}, 32'd2);
      end
      bus.out_ready = 1'b1;
      tick(); check_out("t2_pc8", 1'b1, 32'h8, 32'h0011_2233);
`ifdef IFETCH_PERF_EN
      check_val("t2_stall_cnt", perf_stall_cnt, 32'd3);
      check_val("t2_fetch_cnt", perf_fetch_cnt, 32'd2);
`endif

      // redirect coinciding with an accepting handshake
      redirect_valid = 1'b1; redirect_pc = 32'h10;
      tick(); check_out("t3_flush", 1'b0, 32'h0, 32'h0000_0013);
      redirect_valid = 1'b0;
      tick(); check_out("t3_pc10", 1'b1, 32'h10, 32'h1122_7799);
      tick(); check_out("t3_pc14", 1'b1, 32'h14, 32'h5566_7788);

      // address aliasing past the ROM
      redirect_valid = 1'b1; redirect_pc = 32'h3FFC;
      tick(); check_out("t5_flush", 1'b0, 32'h0, 32'h0000_0013);
      check_val("t5_addr_fff", {20'd0, rom_addr}, 32'hFFF);
      redirect_valid = 1'b0;
      tick(); check_out("t5_pc3ffc", 1'b1, 32'h3FFC, 32'hFEED_F00D);
      check_val("t5_addr_000", {20'd0, rom_addr}, 32'h0);
      tick(); check_out("t5_pc4000", 1'b1, 32'h4000, 32'h1122_3344);

      // misaligned redirect halts
      redirect_valid = 1'b1; redirect_pc = 32'h6;
      tick();
      check_out("t4_halt", 1'b0, 32'h0, 32'h0000_0013);
      check_val("t4_err", {31'd0, fetch_err}, 32'd1);
      check_val("t4_addr", {20'd0, rom_addr}, 32'd1);
      redirect_pc = 32'h20;
      for (int i = 0; i < 3; i++) begin
         fetch_en = i[0];
         tick();
         check_out("t4_frozen", 1'b0, 32'h0, 32'h0000_0013);
         check_val("t4_err_sticky", {31'd0, fetch_err}, 32'd1);
         check_val("t4_addr_frozen", {20'd0, rom_addr}, 32'd1);
      end
`ifdef IFETCH_PERF_EN
      check_val("t4_fetch_cnt", perf_fetch_cnt, 32'd7);
      check_val("t4_stall_cnt", perf_stall_cnt, 32'd3);
`endif
      redirect_valid = 1'b0; fetch_en = 1'b0;
      #2 reset = 1'b1;
      #1;
      check_val("t4_err_clr", {31'd0, fetch_err}, 32'd0);
      check_val("t4_rst_addr", {20'd0, rom_addr}, 32'd0);
      tick();
      reset = 1'b0;
      tick(); check_out("t4_idle", 1'b0, 32'h0, 32'h0000_0013);

      // redirect while idle, then fetch with decode stalled
      redirect_valid = 1'b1; redirect_pc = 32'h8;
      tick();
      check_out("idle_redir", 1'b0, 32'h0, 32'h0000_0013);
      check_val("idle_redir_addr", {20'd0, rom_addr}, 32'd2);
      redirect_valid = 1'b0; fetch_en = 1'b1; bus.out_ready = 1'b0;
      tick(); check_out("t6_run", 1'b0, 32'h0, 32'h0000_0013);
      tick(); check_out("t6_pc8", 1'b1, 32'h8, 32'h0011_2233);
      check_val("t6_addr", {20'd0, rom_addr}, 32'd3);
      tick(); check_out("t6_hold", 1'b1, 32'h8, 32'h0011_2233);

      // asynchronous reset mid-stream
      #2 reset = 1'b1;
      #1;
      check_out("t6_async", 1'b0, 32'h0, 32'h0000_0013);
      check_val("t6_async_pc", bus.out_pc, 32'h0);
      check_val("t6_async_addr", {20'd0, rom_addr}, 32'd0);
`ifdef IFETCH_PERF_EN
      check_val("t6_fetch_cnt", perf_fetch_cnt, 32'd0);
      check_val("t6_stall_cnt", perf_stall_cnt, 32'd0);
`endif
      tick();
      reset = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
